// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS32 control FSM: sequences fetch/decode/exec/mem/writeback over a shared
// memory port, decodes op/func from the IR, and traps on illegal opcodes or bus timeouts.
module mips_multicycle_ctrl #(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] op,
   input  logic [5:0] func,
   input  logic       alu_zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       iord,
   output logic       ir_we,
   output logic       pc_we,
   output logic [1:0] pc_sel,
   output logic [3:0] alu_op,
   output logic [1:0] alu_b_sel,
   output logic       reg_we,
   output logic [1:0] dst_sel,
   output logic [1:0] wb_sel,
   output logic       inst_done,
   output logic       illegal,
   output logic       bus_err,
   output logic [2:0] state
);

   localparam logic [7:0] TIMER_LIM = 8'(TIMEOUT_CYC);

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_SLT = 4'd4;
   localparam logic [3:0] ALU_SLL = 4'd5;
   localparam logic [3:0] ALU_LUI = 4'd6;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd7
   } state_t;

   state_t     cur, nxt;
   logic [7:0] timer_q;
   logic       illegal_q, bus_err_q;
   logic       illegal_set, bus_err_set;
   logic       timer_hit, br_take;

   logic r_type, f_add, f_sub, f_and, f_or, f_slt, f_sll, f_jr, r_alu;
   logic i_addi, i_andi, i_ori, i_lui, i_lw, i_sw, i_beq, i_bne, i_j, i_jal, legal;

   assign r_type = (op == 6'h00);
   assign f_add  = r_type && (func == 6'h20);
   assign f_sub  = r_type && (func == 6'h22);
   assign f_and  = r_type && (func == 6'h24);
   assign f_or   = r_type && (func == 6'h25);
   assign f_slt  = r_type && (func == 6'h2A);
   assign f_sll  = r_type && (func == 6'h00);
   assign f_jr   = r_type && (func == 6'h08);
   assign r_alu  = f_add | f_sub | f_and | f_or | f_slt | f_sll;

   assign i_addi = (op == 6'h08);
   assign i_andi = (op == 6'h0C);
   assign i_ori  = (op == 6'h0D);
   assign i_lui  = (op == 6'h0F);
   assign i_lw   = (op == 6'h23);
   assign i_sw   = (op == 6'h2B);
   assign i_beq  = (op == 6'h04);
   assign i_bne  = (op == 6'h05);
   assign i_j    = (op == 6'h02);
   assign i_jal  = (op == 6'h03);

   assign legal  = r_alu | f_jr | i_addi | i_andi | i_ori | i_lui | i_lw | i_sw |
                   i_beq | i_bne | i_j | i_jal;

   // A pending request times out on the cycle the wait count would reach the limit.
   assign timer_hit = ((timer_q + 8'd1) == TIMER_LIM);
   assign br_take   = (i_beq & alu_zero) | (i_bne & ~alu_zero);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cur       <= S_FETCH;
         timer_q   <= '0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         cur       <= nxt;
         illegal_q <= illegal_q | illegal_set;
         bus_err_q <= bus_err_q | bus_err_set;
         // Leaving FETCH/MEM needs mem_ready, so clearing on any non-waiting cycle
         // is the same as clearing on entry to those states.
         if (mem_req && !mem_ready) timer_q <= timer_q + 8'd1;
         else                       timer_q <= '0;
      end
   end

   always_comb begin
      nxt         = cur;
      illegal_set = 1'b0;
      bus_err_set = 1'b0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      iord        = 1'b0;
      ir_we       = 1'b0;
      pc_we       = 1'b0;
      pc_sel      = 2'd0;
      alu_op      = ALU_ADD;
      alu_b_sel   = 2'd0;
      reg_we      = 1'b0;
      dst_sel     = 2'd0;
      wb_sel      = 2'd0;
      inst_done   = 1'b0;

      case (cur)
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_we = 1'b1;
               pc_we = 1'b1;
               nxt   = S_DECODE;
            end else if (timer_hit) begin
               bus_err_set = 1'b1;
               nxt         = S_TRAP;
            end
         end
         S_DECODE: begin
            if (legal) nxt = S_EXEC;
            else begin
               illegal_set = 1'b1;
               nxt         = S_TRAP;
            end
         end
         S_EXEC: begin
            if (r_alu) begin
               if (f_sub)      alu_op = ALU_SUB;
               else if (f_and) alu_op = ALU_AND;
               else if (f_or)  alu_op = ALU_OR;
               else if (f_slt) alu_op = ALU_SLT;
               else if (f_sll) alu_op = ALU_SLL;
               nxt = S_WB;
            end else if (f_jr) begin
               pc_we     = 1'b1;
               pc_sel    = 2'd3;
               inst_done = 1'b1;
               nxt       = S_FETCH;
            end else if (i_addi | i_lw | i_sw) begin
               alu_b_sel = 2'd1;
               nxt       = (i_lw | i_sw) ? S_MEM : S_WB;
            end else if (i_andi | i_ori | i_lui) begin
               alu_op    = i_andi ? ALU_AND : (i_ori ? ALU_OR : ALU_LUI);
               alu_b_sel = 2'd2;
               nxt       = S_WB;
            end else if (i_beq | i_bne) begin
               alu_op    = ALU_SUB;
               pc_we     = br_take;
               pc_sel    = br_take ? 2'd1 : 2'd0;
               inst_done = 1'b1;
               nxt       = S_FETCH;
            end else if (i_j | i_jal) begin
               pc_we     = 1'b1;
               pc_sel    = 2'd2;
               inst_done = i_j;
               nxt       = i_j ? S_FETCH : S_WB;
            end else begin
               illegal_set = 1'b1;
               nxt         = S_TRAP;
            end
         end
         S_MEM: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            mem_we  = i_sw;
            if (mem_ready) begin
               inst_done = i_sw;
               nxt       = i_sw ? S_FETCH : S_WB;
            end else if (timer_hit) begin
               bus_err_set = 1'b1;
               nxt         = S_TRAP;
            end
         end
         S_WB: begin
            reg_we    = 1'b1;
            dst_sel   = i_jal ? 2'd2 : (r_type ? 2'd1 : 2'd0);
            wb_sel    = i_jal ? 2'd2 : (i_lw ? 2'd1 : 2'd0);
            inst_done = 1'b1;
            nxt       = S_FETCH;
         end
         S_TRAP: nxt = S_TRAP;
         default: nxt = S_FETCH;
      endcase

      if (!rst_n) begin
         mem_req   = 1'b0;
         mem_we    = 1'b0;
         iord      = 1'b0;
         ir_we     = 1'b0;
         pc_we     = 1'b0;
         pc_sel    = 2'd0;
         alu_op    = ALU_ADD;
         alu_b_sel = 2'd0;
         reg_we    = 1'b0;
         dst_sel   = 2'd0;
         wb_sel    = 2'd0;
         inst_done = 1'b0;
      end
   end

   assign illegal = rst_n & illegal_q;
   assign bus_err = rst_n & bus_err_q;
   assign state   = rst_n ? 3'(cur) : 3'd0;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: per-cycle expected output vectors for each
// instruction class, trap paths and reset, with a short bus timeout limit.
module tb_mips_multicycle_ctrl;

   logic       clk, rst_n, alu_zero, mem_ready;
   logic [5:0] op, func;
   logic       mem_req, mem_we, iord, ir_we, pc_we, reg_we, inst_done, illegal, bus_err;
   logic [1:0] pc_sel, alu_b_sel, dst_sel, wb_sel;
   logic [3:0] alu_op;
   logic [2:0] state;

   int nerr, nchk;
   logic [23:0] fw, fr, dc, z, tb_be;

   mips_multicycle_ctrl #(.TIMEOUT_CYC(4)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .func(func), .alu_zero(alu_zero),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
      .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .alu_op(alu_op),
      .alu_b_sel(alu_b_sel), .reg_we(reg_we), .dst_sel(dst_sel), .wb_sel(wb_sel),
      .inst_done(inst_done), .illegal(illegal), .bus_err(bus_err), .state(state)
   );

   always #5 clk = ~clk;

   // Field order: mem_req mem_we iord ir_we pc_we pc_sel alu_op alu_b_sel reg_we dst_sel wb_sel inst_done illegal bus_err state
   function automatic logic [23:0] pk(input int mr, mw, io, ir, pw, ps, ao, bs, rw, ds, ws, id, il, be, st);
      return {1'(mr), 1'(mw), 1'(io), 1'(ir), 1'(pw), 2'(ps), 4'(ao), 2'(bs),
              1'(rw), 2'(ds), 2'(ws), 1'(id), 1'(il), 1'(be), 3'(st)};
   endfunction

   function automatic logic [23:0] obs();
      return {mem_req, mem_we, iord, ir_we, pc_we, pc_sel, alu_op, alu_b_sel,
              reg_we, dst_sel, wb_sel, inst_done, illegal, bus_err, state};
   endfunction

   task automatic test_reset;
      logic [1:0]  ctl [4];
      logic [23:0] ex  [4];
      ctl = '{2'b01, 2'b01, 2'b01, 2'b10};
      ex  = '{z, z, z, fw};
      for (int i = 0; i < 4; i++) begin
         {rst_n, mem_ready} = ctl[i]; #1;
         nchk++;
         if (obs() !== ex[i]) begin
            nerr++; $display("FAIL reset[%0d]: got %h want %h", i, obs(), ex[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_r_type;
      logic [5:0]  fn [6];
      int          ao [6];
      logic [23:0] ex [5];
      fn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
      ao = '{0, 1, 2, 3, 4, 5};
      for (int k = 0; k < 6; k++) begin
         op = 6'h00; func = fn[k];
         ex = '{fr, dc, pk(0,0,0,0,0,0,ao[k],0,0,0,0,0,0,0,2),
                pk(0,0,0,0,0,0,0,0,1,1,0,1,0,0,4), fw};
         for (int i = 0; i < 5; i++) begin
            mem_ready = (i < 4); #1;
            nchk++;
            if (obs() !== ex[i]) begin
               nerr++; $display("FAIL rtype_f%h[%0d]: got %h want %h", fn[k], i, obs(), ex[i]);
            end
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_lw_wait;
      logic [1:0]  ctl [9];
      logic [23:0] ex  [9];
      logic [23:0] mw;
      op = 6'h23; func = 6'h00;
      mw  = pk(1,0,1,0,0,0,0,0,0,0,0,0,0,0,3);
      ctl = '{2'b11, 2'b11, 2'b11, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b10};
      ex  = '{fr, dc, pk(0,0,0,0,0,0,0,1,0,0,0,0,0,0,2), mw, mw, mw, mw,
              pk(0,0,0,0,0,0,0,0,1,0,1,1,0,0,4), fw};
      for (int i = 0; i < 9; i++) begin
         {rst_n, mem_ready} = ctl[i]; #1;
         nchk++;
         if (obs() !== ex[i]) begin
            nerr++; $display("FAIL lw_wait[%0d]: got %h want %h", i, obs(), ex[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_sw;
      logic [23:0] ex [5];
      op = 6'h2B; func = 6'h00;
      ex = '{fr, dc, pk(0,0,0,0,0,0,0,1,0,0,0,0,0,0,2),
             pk(1,1,1,0,0,0,0,0,0,0,0,1,0,0,3), fw};
      for (int i = 0; i < 5; i++) begin
         mem_ready = (i < 4); #1;
         nchk++;
         if (obs() !== ex[i]) begin
            nerr++; $display("FAIL sw[%0d]: got %h want %h", i, obs(), ex[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_branch;
      logic [5:0]  bop [4];
      logic        bz  [4];
      int          tk  [4];
      logic [23:0] ex  [4];
      bop = '{6'h04, 6'h04, 6'h05, 6'h05};
      bz  = '{1'b1, 1'b0, 1'b0, 1'b1};
      tk  = '{1, 0, 1, 0};
      for (int k = 0; k < 4; k++) begin
         op = bop[k]; func = 6'h00; alu_zero = bz[k];
         ex = '{fr, dc, pk(0,0,0,0,tk[k],tk[k],1,0,0,0,0,1,0,0,2), fw};
         for (int i = 0; i < 4; i++) begin
            mem_ready = (i < 3); #1;
            nchk++;
            if (obs() !== ex[i]) begin
               nerr++; $display("FAIL branch%0d[%0d]: got %h want %h", k, i, obs(), ex[i]);
            end
            @(posedge clk); #1;
         end
      end
      alu_zero = 1'b0;
   endtask

   task automatic test_jumps;
      logic [5:0]  jop [2];
      logic [5:0]  jfn [2];
      int          ps  [2];
      logic [23:0] ex  [4];
      jop = '{6'h02, 6'h00};
      jfn = '{6'h00, 6'h08};
      ps  = '{2, 3};
      for (int k = 0; k < 2; k++) begin
         op = jop[k]; func = jfn[k];
         ex = '{fr, dc, pk(0,0,0,0,1,ps[k],0,0,0,0,0,1,0,0,2), fw};
         for (int i = 0; i < 4; i++) begin
            mem_ready = (i < 3); #1;
            nchk++;
            if (obs() !== ex[i]) begin
               nerr++; $display("FAIL jump%0d[%0d]: got %h want %h", k, i, obs(), ex[i]);
            end
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_jal;
      logic [23:0] ex [5];
      op = 6'h03; func = 6'h00;
      ex = '{fr, dc, pk(0,0,0,0,1,2,0,0,0,0,0,0,0,0,2),
             pk(0,0,0,0,0,0,0,0,1,2,2,1,0,0,4), fw};
      for (int i = 0; i < 5; i++) begin
         mem_ready = (i < 4); #1;
         nchk++;
         if (obs() !== ex[i]) begin
            nerr++; $display("FAIL jal[%0d]: got %h want %h", i, obs(), ex[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_i_alu;
      logic [5:0]  iop [3];
      int          ao  [3];
      int          bs  [3];
      logic [23:0] ex  [5];
      iop = '{6'h08, 6'h0C, 6'h0D};
      ao  = '{0, 2, 3};
      bs  = '{1, 2, 2};
      for (int k = 0; k < 3; k++) begin
         op = iop[k]; func = 6'h20;
         ex = '{fr, dc, pk(0,0,0,0,0,0,ao[k],bs[k],0,0,0,0,0,0,2),
                pk(0,0,0,0,0,0,0,0,1,0,0,1,0,0,4), fw};
         for (int i = 0; i < 5; i++) begin
            mem_ready = (i < 4); #1;
            nchk++;
            if (obs() !== ex[i]) begin
               nerr++; $display("FAIL ialu_op%h[%0d]: got %h want %h", iop[k], i, obs(), ex[i]);
            end
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_fetch_limit;
      logic [1:0]  ctl [12];
      logic [23:0] ex  [12];
      logic [23:0] es, ms;
      op = 6'h2B; func = 6'h00;
      es  = pk(0,0,0,0,0,0,0,1,0,0,0,0,0,0,2);
      ms  = pk(1,1,1,0,0,0,0,0,0,0,0,1,0,0,3);
      ctl = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b10, 2'b10, 2'b11,
              2'b11, 2'b11, 2'b11, 2'b10};
      ex  = '{fr, dc, es, ms, fw, fw, fw, fr, dc, es, ms, fw};
      for (int i = 0; i < 12; i++) begin
         {rst_n, mem_ready} = ctl[i]; #1;
         nchk++;
         if (obs() !== ex[i]) begin
            nerr++; $display("FAIL fetch_limit[%0d]: got %h want %h", i, obs(), ex[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_illegal;
      logic [5:0]  iop [2];
      logic [5:0]  ifn [2];
      logic [1:0]  ctl [6];
      logic [23:0] ex  [6];
      logic [23:0] tr;
      iop = '{6'h3F, 6'h00};
      ifn = '{6'h00, 6'h3F};
      tr  = pk(0,0,0,0,0,0,0,0,0,0,0,0,1,0,7);
      ctl = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b10};
      ex  = '{fr, dc, tr, tr, z, fw};
      for (int k = 0; k < 2; k++) begin
         op = iop[k]; func = ifn[k];
         for (int i = 0; i < 6; i++) begin
            {rst_n, mem_ready} = ctl[i]; #1;
            nchk++;
            if (obs() !== ex[i]) begin
               nerr++; $display("FAIL illegal%0d[%0d]: got %h want %h", k, i, obs(), ex[i]);
            end
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_bus_timeout;
      logic [1:0]  ctl [9];
      logic [23:0] ex  [9];
      op = 6'h00; func = 6'h20;
      ctl = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b01, 2'b10};
      ex  = '{z, fw, fw, fw, fw, tb_be, tb_be, z, fw};
      for (int i = 0; i < 9; i++) begin
         {rst_n, mem_ready} = ctl[i]; #1;
         nchk++;
         if (obs() !== ex[i]) begin
            nerr++; $display("FAIL bus_timeout[%0d]: got %h want %h", i, obs(), ex[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_mem_timeout;
      logic [1:0]  ctl [11];
      logic [23:0] ex  [11];
      logic [23:0] mw;
      op = 6'h2B; func = 6'h00;
      mw  = pk(1,1,1,0,0,0,0,0,0,0,0,0,0,0,3);
      ctl = '{2'b00, 2'b11, 2'b11, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10,
              2'b10, 2'b01, 2'b10};
      ex  = '{z, fr, dc, pk(0,0,0,0,0,0,0,1,0,0,0,0,0,0,2), mw, mw, mw, mw, tb_be, z, fw};
      for (int i = 0; i < 11; i++) begin
         {rst_n, mem_ready} = ctl[i]; #1;
         nchk++;
         if (obs() !== ex[i]) begin
            nerr++; $display("FAIL mem_timeout[%0d]: got %h want %h", i, obs(), ex[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid;
      logic [1:0]  ctl [7];
      logic [23:0] ex  [7];
      op = 6'h23; func = 6'h00;
      ctl = '{2'b00, 2'b11, 2'b11, 2'b11, 2'b10, 2'b00, 2'b10};
      ex  = '{z, fr, dc, pk(0,0,0,0,0,0,0,1,0,0,0,0,0,0,2),
              pk(1,0,1,0,0,0,0,0,0,0,0,0,0,0,3), z, fw};
      for (int i = 0; i < 7; i++) begin
         {rst_n, mem_ready} = ctl[i]; #1;
         nchk++;
         if (obs() !== ex[i]) begin
            nerr++; $display("FAIL reset_mid[%0d]: got %h want %h", i, obs(), ex[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      clk = 1'b0; rst_n = 1'b0; mem_ready = 1'b1; alu_zero = 1'b0;
      op = 6'h00; func = 6'h20;
      nerr = 0; nchk = 0;
      fw    = pk(1,0,0,0,0,0,0,0,0,0,0,0,0,0,0);
      fr    = pk(1,0,0,1,1,0,0,0,0,0,0,0,0,0,0);
      dc    = pk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,1);
      z     = '0;
      tb_be = pk(0,0,0,0,0,0,0,0,0,0,0,0,0,1,7);

      test_reset;
      test_r_type;
      test_lw_wait;
      test_sw;
      test_branch;
      test_jumps;
      test_jal;
      test_i_alu;
      test_fetch_limit;
      test_illegal;
      test_bus_timeout;
      test_mem_timeout;
      test_reset_mid;

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
